fir_result_fifo: RTL and testbench

Downstream stage of the FIR engine: accepts the filtered output stream (`sm_*` AXI-Stream) and buffers it in a first-word-fall-through FIFO. Buffered samples are exposed to the user-project bus logic through a valid/ready pop port. The block also keeps per-frame statistics: sample count, modular checksum and a sticky frame-done flag, which firmware polls to confirm that a full `data_length` run completed.

---
 rtl/fir_result_fifo_if.sv | 24 ++
 rtl/fir_result_fifo.sv | 97 +++++++++
 tb/tb_fir_result_fifo.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_result_fifo_if.sv
// Stream-side and pop-side handshake bundle for the FIR result FIFO.
// slave is the FIFO's view; master is the producer/consumer view.
interface fir_result_fifo_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic                   sm_tready;
    logic                   rd_valid;
    logic [pDATA_WIDTH-1:0] rd_data;
    logic                   rd_last;
    logic                   rd_ready;

    modport slave (
        input  sm_tvalid, sm_tdata, sm_tlast, rd_ready,
        output sm_tready, rd_valid, rd_data, rd_last
    );

    modport master (
        output sm_tvalid, sm_tdata, sm_tlast, rd_ready,
        input  sm_tready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/fir_result_fifo.sv
// First-word-fall-through buffer for the FIR output stream, with per-frame
// sample count, modular checksum and sticky frame-done statistics.
module fir_result_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst,
    fir_result_fifo_if.slave      bus,
    input  logic                  flush,
    input  logic                  clr_stats,
    output logic [DEPTH_LOG2:0]   fill,
    output logic [31:0]           sample_cnt,
    output logic [31:0]           checksum,
    output logic                  frame_done
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_C   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] FILL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [pDATA_WIDTH:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_fill;
    logic [31:0]             r_sample_cnt;
    logic [31:0]             r_checksum;
    logic                    r_frame_done;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_store;
    logic [pDATA_WIDTH:0]    w_head;

    // Ready depends only on registered occupancy, so a pop never admits a push when full.
    assign bus.sm_tready = !axis_rst && (r_fill != FULL_C);
    assign bus.rd_valid  = (r_fill != '0);
    assign w_push        = bus.sm_tvalid && bus.sm_tready;
    assign w_pop         = bus.rd_valid && bus.rd_ready;
    assign w_store       = w_push && !flush;

    assign w_head       = r_mem[r_rd_ptr];
    assign bus.rd_data  = w_head[pDATA_WIDTH-1:0];
    assign bus.rd_last  = w_head[pDATA_WIDTH];

    assign fill       = r_fill;
    assign sample_cnt = r_sample_cnt;
    assign checksum   = r_checksum;
    assign frame_done = r_frame_done;

    always_ff @(posedge axis_clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= {bus.sm_tlast, bus.sm_tdata};
        end
    end

    // A beat arriving with flush is not stored, so rd_ptr can simply jump to wr_ptr.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_fill   <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_store, w_pop})
                2'b10:   r_fill <= r_fill + FILL_ONE;
                2'b01:   r_fill <= r_fill - FILL_ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Clear acts before the same-cycle beat, so that beat starts the new frame.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_sample_cnt <= '0;
            r_checksum   <= '0;
            r_frame_done <= 1'b0;
        end else if (clr_stats) begin
            r_sample_cnt <= w_push ? 32'd1 : 32'd0;
            r_checksum   <= w_push ? 32'(bus.sm_tdata) : 32'd0;
            r_frame_done <= w_push && bus.sm_tlast;
        end else if (w_push) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
            r_checksum   <= r_checksum + 32'(bus.sm_tdata);
            r_frame_done <= r_frame_done | bus.sm_tlast;
        end
    end
endmodule

// File: tb/tb_fir_result_fifo.sv
// Self-checking bench for fir_result_fifo: vector table, corner sequences and
// a random run, all compared against a queue-based reference model.
module tb_fir_result_fifo;
    localparam int W     = 32;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        clr_stats;
    logic [DL:0] fill;
    logic [31:0] sample_cnt;
    logic [31:0] checksum;
    logic        frame_done;

    fir_result_fifo_if #(.pDATA_WIDTH(W)) bus_if ();

    fir_result_fifo #(.pDATA_WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .axis_clk   (clk),
        .axis_rst   (rst),
        .bus        (bus_if),
        .flush      (flush),
        .clr_stats  (clr_stats),
        .fill       (fill),
        .sample_cnt (sample_cnt),
        .checksum   (checksum),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is a queue of {tlast, tdata}; statistics are plain counters.
    logic [32:0] mq[$];
    logic [31:0] m_cnt;
    logic [31:0] m_sum;
    logic        m_done;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        rr;
        logic        fl;
        logic        cl;
        logic [4:0]  e_fill;
        logic [31:0] e_cnt;
        logic [31:0] e_sum;
        logic        e_done;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_compare();
        int n;
        n = mq.size();
        check("sm_tready", 64'(bus_if.sm_tready), 64'(!rst && (n < DEPTH)));
        check("rd_valid", 64'(bus_if.rd_valid), 64'(n != 0));
        check("fill", 64'(fill), 64'(n));
        check("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
        check("checksum", 64'(checksum), 64'(m_sum));
        check("frame_done", 64'(frame_done), 64'(m_done));
        if (n != 0) begin
            check("rd_data", 64'(bus_if.rd_data), 64'(mq[0][31:0]));
            check("rd_last", 64'(bus_if.rd_last), 64'(mq[0][32]));
        end
    endtask

    // Called at posedge+1: drive, compare at the falling edge, advance the model, cross the edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                         input logic rr, input logic fl, input logic cl);
        bit push;
        bit pop;
        bus_if.sm_tvalid = v;
        bus_if.sm_tdata  = d;
        bus_if.sm_tlast  = l;
        bus_if.rd_ready  = rr;
        flush            = fl;
        clr_stats        = cl;
        #4;
        model_compare();
        push = v && !rst && (mq.size() < DEPTH);
        pop  = rr && (mq.size() != 0);
        if (rst) begin
            mq.delete();
            m_cnt  = '0;
            m_sum  = '0;
            m_done = 1'b0;
        end else begin
            if (cl) begin
                m_cnt  = '0;
                m_sum  = '0;
                m_done = 1'b0;
            end
            if (push) begin
                m_cnt  = m_cnt + 32'd1;
                m_sum  = m_sum + d;
                m_done = m_done | l;
            end
            if (fl) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back({l, d});
            end
        end
        if (push || pop || fl || cl || rst)
            $display("t=%0t push=%0d d=%h last=%0d pop=%0d flush=%0d clr=%0d rst=%0d fill_next=%0d",
                     $time, push, d, l, pop && !fl && !rst, fl, cl, rst, mq.size());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        flush            = 1'b0;
        clr_stats        = 1'b0;
        bus_if.sm_tvalid = 1'b0;
        bus_if.sm_tdata  = '0;
        bus_if.sm_tlast  = 1'b0;
        bus_if.rd_ready  = 1'b0;
        m_cnt            = '0;
        m_sum            = '0;
        m_done           = 1'b0;

        //            v     d             l     rr    fl    cl    fill   cnt    sum           done
        tbl[0]  = '{1'b1, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'd1, 32'd1,        1'b0};
        tbl[1]  = '{1'b1, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'd2, 32'd3,        1'b0};
        tbl[2]  = '{1'b1, 32'd3,        1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'd3, 32'd6,        1'b0};
        tbl[3]  = '{1'b1, 32'd4,        1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 32'd4, 32'd10,       1'b0};
        tbl[4]  = '{1'b1, 32'd5,        1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'd5, 32'd15,       1'b1};
        tbl[5]  = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'd5, 32'd15,       1'b1};
        tbl[6]  = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'd5, 32'd15,       1'b1};
        tbl[7]  = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'd5, 32'd15,       1'b1};
        tbl[8]  = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'd5, 32'd15,       1'b1};
        tbl[9]  = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd5, 32'd15,       1'b1};
        tbl[10] = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd1, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{1'b1, 32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'd2, 32'd1,        1'b0};
        tbl[12] = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'd2, 32'd1,        1'b0};
        tbl[13] = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd2, 32'd1,        1'b0};
        tbl[14] = '{1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd2, 32'd1,        1'b0};
        tbl[15] = '{1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0,        1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_fill", 64'(fill), 64'(0));
        check("reset_rd_valid", 64'(bus_if.rd_valid), 64'(0));
        check("reset_sm_tready", 64'(bus_if.sm_tready), 64'(0));
        check("reset_sample_cnt", 64'(sample_cnt), 64'(0));
        check("reset_checksum", 64'(checksum), 64'(0));
        check("reset_frame_done", 64'(frame_done), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rr, tbl[i].fl, tbl[i].cl);
            check($sformatf("tbl%0d_fill", i), 64'(fill), 64'(tbl[i].e_fill));
            check($sformatf("tbl%0d_cnt", i), 64'(sample_cnt), 64'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_sum", i), 64'(checksum), 64'(tbl[i].e_sum));
            check($sformatf("tbl%0d_done", i), 64'(frame_done), 64'(tbl[i].e_done));
        end

        // Fill to capacity, then hold a 17th beat until one pop frees a slot.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'(100 + i), i == DEPTH - 1, 1'b0, 1'b0, 1'b0);
        check("full_fill", 64'(fill), 64'(16));
        check("full_tready", 64'(bus_if.sm_tready), 64'(0));
        repeat (3) cycle(1'b1, 32'd200, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_held_fill", 64'(fill), 64'(16));
        check("full_held_cnt", 64'(sample_cnt), 64'(16));
        cycle(1'b1, 32'd200, 1'b0, 1'b1, 1'b0, 1'b0);
        check("full_pop_fill", 64'(fill), 64'(15));
        check("full_pop_cnt", 64'(sample_cnt), 64'(16));
        cycle(1'b1, 32'd200, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_refill", 64'(fill), 64'(16));
        check("full_refill_cnt", 64'(sample_cnt), 64'(17));
        repeat (DEPTH) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("drain_fill", 64'(fill), 64'(0));

        // Streaming with the consumer always ready, across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 32'(1000 + i), i == 39, 1'b1, 1'b0, 1'b0);
            check("stream_fill_le1", 64'(fill <= 1), 64'(1));
        end
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("stream_cnt", 64'(sample_cnt), 64'(57));

        // Clear together with a push after nine counted beats.
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 32'd3, i == 8, 1'b1, 1'b0, 1'b0);
        check("pre_clr_cnt", 64'(sample_cnt), 64'(9));
        check("pre_clr_done", 64'(frame_done), 64'(1));
        cycle(1'b1, 32'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_push_cnt", 64'(sample_cnt), 64'(1));
        check("clr_push_sum", 64'(checksum), 64'(7));
        check("clr_push_done", 64'(frame_done), 64'(0));
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Flush with a simultaneous pop and push at fill 3.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'(11 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_flush_fill", 64'(fill), 64'(3));
        cycle(1'b1, 32'd14, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_fill", 64'(fill), 64'(0));
        check("flush_rd_valid", 64'(bus_if.rd_valid), 64'(0));
        check("flush_cnt", 64'(sample_cnt), 64'(5));
        cycle(1'b1, 32'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_flush_fill", 64'(fill), 64'(1));

        // Reset mid-stream with a beat presented.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'(40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b1, 32'd55, 1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst_fill", 64'(fill), 64'(0));
        check("midrst_rd_valid", 64'(bus_if.rd_valid), 64'(0));
        check("midrst_tready", 64'(bus_if.sm_tready), 64'(0));
        check("midrst_cnt", 64'(sample_cnt), 64'(0));
        check("midrst_sum", 64'(checksum), 64'(0));
        check("midrst_done", 64'(frame_done), 64'(0));
        rst = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cycle(1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 29) == 0));
        end
        rst = 1'b0;
        repeat (DEPTH + 1) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
